// File: rtl/adpll_pkg.sv
// Shared types and widths for the ADPLL phase detector.
package adpll_pkg;

  localparam int PERIOD_W = 10;
  localparam int ERR_W    = 10;

  typedef enum logic [1:0] {
    IDLE,
    REF_FIRST,
    FB_FIRST
  } phase_state_t;

  // Counters stop at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/adpll_edge_sync.sv
// Two-flop synchronizer plus history flop; rise is combinational on the synced level.
// Input change shows up on rise two clk cycles later; no backpressure.
module adpll_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise
);

  logic meta;
  logic synced;
  logic hist;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta   <= 1'b0;
      synced <= 1'b0;
      hist   <= 1'b0;
    end else begin
      meta   <= sig;
      synced <= meta;
      hist   <= synced;
    end
  end

  assign rise = synced & ~hist;

endmodule

// File: rtl/adpll_phase_detect.sv
// Reference period measurement and ref/fb phase comparison driving DCO add/sub requests.
// All outputs registered one cycle after the internal edge event; no backpressure.
module adpll_phase_detect
  import adpll_pkg::*;
#(
  parameter int DEADBAND = 2,
  parameter int LOCK_CNT = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ref_in,
  input  logic                fb_in,
  output logic                ref_rise,
  output logic [PERIOD_W-1:0] ref_period,
  output logic                period_valid,
  output logic                add_pulse,
  output logic                sub_pulse,
  output logic                locked
);

  localparam int LW = $clog2(LOCK_CNT + 1);

  logic ref_ev;
  logic fb_ev;

  adpll_edge_sync u_ref_sync (
    .clk  (clk),
    .rst  (rst),
    .sig  (ref_in),
    .rise (ref_ev)
  );

  adpll_edge_sync u_fb_sync (
    .clk  (clk),
    .rst  (rst),
    .sig  (fb_in),
    .rise (fb_ev)
  );

  // Period measurement: the first edge after reset only arms the counter.
  logic [PERIOD_W-1:0] per_cnt;
  logic                seen_ref;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_cnt      <= '0;
      seen_ref     <= 1'b0;
      ref_rise     <= 1'b0;
      ref_period   <= '0;
      period_valid <= 1'b0;
    end else begin
      ref_rise <= ref_ev;
      if (ref_ev) begin
        per_cnt    <= PERIOD_W'(1);
        ref_period <= per_cnt;
        seen_ref   <= 1'b1;
        if (seen_ref) period_valid <= 1'b1;
      end else begin
        per_cnt <= sat_inc(per_cnt);
      end
    end
  end

  phase_state_t     state;
  logic [ERR_W-1:0] err_cnt;

  logic             eval;
  logic             lag;
  logic             force_out;
  logic [ERR_W-1:0] err;
  logic             out_band;
  logic             in_band;

  always_comb begin
    eval      = 1'b0;
    lag       = 1'b0;
    force_out = 1'b0;
    err       = '0;
    case (state)
      IDLE: begin
        if (ref_ev && fb_ev) eval = 1'b1;
      end
      REF_FIRST: begin
        if (fb_ev) begin
          eval = 1'b1;
          lag  = 1'b1;
          err  = err_cnt;
        end else if (ref_ev) begin
          // Feedback missed a whole reference period: treat as a large lag.
          eval      = 1'b1;
          lag       = 1'b1;
          force_out = 1'b1;
        end
      end
      FB_FIRST: begin
        if (ref_ev) begin
          eval = 1'b1;
          err  = err_cnt;
        end else if (fb_ev) begin
          eval      = 1'b1;
          force_out = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign out_band = eval && (force_out || (err > ERR_W'(DEADBAND)));
  assign in_band  = eval && !out_band;

  // A same-cycle opposite edge closes the comparison; a coincident new lead edge opens the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      err_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ref_ev && !fb_ev) begin
            state   <= REF_FIRST;
            err_cnt <= ERR_W'(1);
          end else if (fb_ev && !ref_ev) begin
            state   <= FB_FIRST;
            err_cnt <= ERR_W'(1);
          end
        end
        REF_FIRST: begin
          if (fb_ev) begin
            if (ref_ev) err_cnt <= ERR_W'(1);
            else        state   <= IDLE;
          end else if (ref_ev) begin
            err_cnt <= ERR_W'(1);
          end else begin
            err_cnt <= sat_inc(err_cnt);
          end
        end
        FB_FIRST: begin
          if (ref_ev) begin
            if (fb_ev) err_cnt <= ERR_W'(1);
            else       state   <= IDLE;
          end else if (fb_ev) begin
            err_cnt <= ERR_W'(1);
          end else begin
            err_cnt <= sat_inc(err_cnt);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  logic [LW-1:0] lock_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      add_pulse <= 1'b0;
      sub_pulse <= 1'b0;
      lock_cnt  <= '0;
      locked    <= 1'b0;
    end else begin
      add_pulse <= out_band && !lag && period_valid;
      sub_pulse <= out_band &&  lag && period_valid;
      if (out_band) begin
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else begin
        if (in_band && (lock_cnt != LW'(LOCK_CNT))) lock_cnt <= lock_cnt + 1'b1;
        locked <= (lock_cnt == LW'(LOCK_CNT));
      end
    end
  end

endmodule

// File: tb/tb_adpll_phase_detect.sv
// Drives scheduled ref/fb pulses and compares every cycle against a timestamp-based reference model.
module tb_adpll_phase_detect;

  localparam int DEADBAND = 2;
  localparam int LOCK_CNT = 8;
  localparam int N        = 12000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ref_in = 1'b0;
  logic       fb_in = 1'b0;
  logic       ref_rise;
  logic [9:0] ref_period;
  logic       period_valid;
  logic       add_pulse;
  logic       sub_pulse;
  logic       locked;

  adpll_phase_detect #(.DEADBAND(DEADBAND), .LOCK_CNT(LOCK_CNT)) dut (
    .clk          (clk),
    .rst          (rst),
    .ref_in       (ref_in),
    .fb_in        (fb_in),
    .ref_rise     (ref_rise),
    .ref_period   (ref_period),
    .period_valid (period_valid),
    .add_pulse    (add_pulse),
    .sub_pulse    (sub_pulse),
    .locked       (locked)
  );

  always #5 clk = ~clk;

  // Input level seen at posedge c
  bit r_lvl [0:N-1];
  bit f_lvl [0:N-1];
  bit rst_lvl [0:N-1];

  int checks = 0;
  int failures = 0;
  int cur_cycle = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d exp=%0d", tag, cur_cycle, got, exp);
    end
  endtask

  task automatic pulse_ref(input int c);
    r_lvl[c] = 1'b1;
    r_lvl[c+1] = 1'b1;
  endtask

  task automatic pulse_fb(input int c);
    f_lvl[c] = 1'b1;
    f_lvl[c+1] = 1'b1;
  endtask

  // Reference model: pending comparison kept as (side, start time)
  int last_ref, nref, pend, ps, streak, e_period;
  bit pv, e_rise, e_add, e_sub, e_lock;

  task automatic model_reset();
    last_ref = -1; nref = 0; pend = 0; ps = 0; streak = 0;
    pv = 0; e_rise = 0; e_add = 0; e_sub = 0; e_lock = 0; e_period = 0;
  endtask

  task automatic model_step(input int c);
    bit rev, fev, ev, lag, out, pv_old;
    int sep;
    if (rst_lvl[c]) begin
      model_reset();
      return;
    end
    rev = (c >= 3) && r_lvl[c-2] && !r_lvl[c-3];
    fev = (c >= 3) && f_lvl[c-2] && !f_lvl[c-3];
    pv_old = pv;
    e_rise = rev;
    ev = 0; lag = 0; out = 0; sep = 0;
    if (rev) begin
      if (last_ref >= 0) e_period = (c - last_ref > 1023) ? 1023 : c - last_ref;
      nref++;
      if (nref >= 2) pv = 1;
      last_ref = c;
    end
    case (pend)
      0: begin
        if (rev && fev) ev = 1;
        else if (rev) begin pend = 1; ps = c; end
        else if (fev) begin pend = 2; ps = c; end
      end
      1: begin
        if (fev) begin
          ev = 1; lag = 1; sep = c - ps;
          if (rev) ps = c; else pend = 0;
        end else if (rev) begin
          ev = 1; lag = 1; out = 1; ps = c;
        end
      end
      default: begin
        if (rev) begin
          ev = 1; sep = c - ps;
          if (fev) ps = c; else pend = 0;
        end else if (fev) begin
          ev = 1; out = 1; ps = c;
        end
      end
    endcase
    if (sep > 1023) sep = 1023;
    if (ev && sep > DEADBAND) out = 1;
    e_add = ev && out && !lag && pv_old;
    e_sub = ev && out && lag && pv_old;
    if (ev && out) begin
      streak = 0;
      e_lock = 0;
    end else begin
      e_lock = (streak >= LOCK_CNT);
      if (ev) streak++;
    end
  endtask

  int rc, ncyc, off, per;

  initial begin
    // Build the stimulus schedule
    for (int c = 0; c < 4; c++) rst_lvl[c] = 1'b1;
    rc = 20;
    pulse_ref(rc); rc += 200;
    pulse_ref(rc); rc += 200;
    pulse_ref(rc); pulse_fb(rc + 5); rc += 200;
    pulse_ref(rc); pulse_fb(rc - 5); rc += 200;
    for (int i = 0; i < 8; i++) begin
      pulse_ref(rc); pulse_fb(rc + 2); rc += 200;
    end
    pulse_ref(rc); pulse_fb(rc + 6); rc += 200;
    for (int i = 0; i < 15; i++) begin
      pulse_ref(rc);
      off = int'($urandom_range(0, 16)) - 8;
      if ($urandom_range(0, 4) != 0) pulse_fb(rc + off);
      per = int'($urandom_range(150, 250));
      rc += per;
    end
    rc += 1100;
    for (int i = 0; i < 3; i++) begin
      pulse_ref(rc); rc += 200;
    end
    pulse_ref(rc); pulse_fb(rc + 10);
    rst_lvl[rc+5] = 1'b1;
    rst_lvl[rc+6] = 1'b1;
    rc += 200;
    for (int i = 0; i < 3; i++) begin
      pulse_ref(rc); pulse_fb(rc + 3); rc += 200;
    end
    ncyc = rc + 100;

    model_reset();
    rst = rst_lvl[0];
    ref_in = r_lvl[0];
    fb_in = f_lvl[0];
    #1;
    check_val("rst_ref_rise", ref_rise, 0);
    check_val("rst_ref_period", ref_period, 0);
    check_val("rst_period_valid", period_valid, 0);
    check_val("rst_add", add_pulse, 0);
    check_val("rst_sub", sub_pulse, 0);
    check_val("rst_locked", locked, 0);

    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk);
      model_step(c);
      @(negedge clk);
      cur_cycle = c;
      check_val("ref_rise", ref_rise, e_rise);
      check_val("period_valid", period_valid, pv);
      check_val("add_pulse", add_pulse, e_add);
      check_val("sub_pulse", sub_pulse, e_sub);
      check_val("locked", locked, e_lock);
      check_val("add_sub_excl", add_pulse & sub_pulse, 0);
      if (pv || rst_lvl[c]) check_val("ref_period", ref_period, e_period);
      rst = rst_lvl[c+1];
      ref_in = r_lvl[c+1];
      fb_in = f_lvl[c+1];
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adpll_phase_detect.md
ADPLL_PHASE_DETECT -- requirements
Module: adpll_phase_detect

Interface
REQ-001 Parameter DEADBAND, default 2: max phase error in clk cycles treated as zero.
REQ-002 Parameter LOCK_CNT, default 8: consecutive in-deadband comparisons required to assert locked.
REQ-003 clk  input  1  system clock; all logic on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 ref_in  input  1  asynchronous reference clock.
REQ-006 fb_in  input  1  asynchronous feedback (DCO ctrl_signal).
REQ-007 ref_rise  output  1  one-cycle pulse per reference rising edge.
REQ-008 ref_period  output  10  last measured reference period in clk cycles.
REQ-009 period_valid  output  1  ref_period holds a real measurement.
REQ-010 add_pulse  output  1  one-cycle request: DCO count limit +1 (feedback leads).
REQ-011 sub_pulse  output  1  one-cycle request: DCO count limit -1 (feedback lags).
REQ-012 locked  output  1  phase within deadband for LOCK_CNT consecutive comparisons.

Function
REQ-013 ref_in and fb_in SHALL each pass a 2-flop synchronizer plus one history flop; an internal edge event SHALL occur when sync output is 1 and history is 0.
REQ-014 ref_rise SHALL be registered, high exactly one cycle, one cycle after the internal ref edge event.
REQ-015 Period counter SHALL load 1 on each ref edge event, otherwise increment by 1, saturating at 1023.
REQ-016 On each ref edge event ref_period SHALL load the counter value (edges 200 cycles apart -> 200); period_valid SHALL set on the second ref edge after reset and stay set.
REQ-017 Phase FSM states SHALL be IDLE, REF_FIRST, FB_FIRST.
REQ-018 IDLE: ref and fb events same cycle -> error 0, evaluate, stay IDLE; ref only -> REF_FIRST; fb only -> FB_FIRST; entry loads err_cnt to 1.
REQ-019 REF_FIRST/FB_FIRST: err_cnt SHALL increment each cycle, saturating at 1023; err_cnt at the opposite event equals edge separation in cycles.
REQ-020 REF_FIRST with fb event: evaluate err_cnt as lag, go IDLE; FB_FIRST with ref event: evaluate as lead, go IDLE.
REQ-021 Repeated same-side event (ref again in REF_FIRST, fb again in FB_FIRST): evaluate as out-of-deadband lag/lead respectively, remain in state, reload err_cnt to 1.
REQ-022 Evaluation with error > DEADBAND SHALL produce sub_pulse (lag) or add_pulse (lead) for exactly one cycle, the cycle after evaluation.
REQ-023 add_pulse and sub_pulse SHALL never be high together and SHALL be suppressed while period_valid is 0.
REQ-024 Each evaluation with error <= DEADBAND SHALL increment lock counter (saturating at LOCK_CNT); locked SHALL assert the cycle after the counter reaches LOCK_CNT.
REQ-025 Any out-of-deadband evaluation SHALL clear the lock counter and deassert locked in the following cycle.

Reset
REQ-026 rst SHALL asynchronously clear synchronizers, history flops, counters, FSM to IDLE, and all outputs to 0 (ref_period = 0, period_valid = 0, locked = 0).
REQ-027 Reset asserted mid-comparison SHALL abandon the comparison with no pulse; the first ref edge after release is not a period measurement.

Structure
REQ-028 Shared package adpll_pkg SHALL hold the FSM state enum, PERIOD_W = 10 and ERR_W = 10 constants.
REQ-029 Sub-module adpll_edge_sync (2-flop sync + history + rise event) SHALL be instantiated once for ref_in and once for fb_in.

Verification
REQ-030 ref_in period 200 clk, three edges -> ref_period = 200, period_valid high from second edge, ref_rise one cycle per edge.
REQ-031 period_valid=1, fb edge 5 cycles after ref edge -> single sub_pulse, no add_pulse.
REQ-032 period_valid=1, fb edge 5 cycles before ref edge -> single add_pulse.
REQ-033 fb 2 cycles after ref for 8 periods -> no pulses, locked high after eighth comparison; then 6-cycle lag -> sub_pulse and locked low.
REQ-034 fb held low, ref edges continue -> one sub_pulse per ref edge after the first, FSM stays REF_FIRST.
REQ-035 rst pulsed 3 cycles after ref edge with fb pending -> all outputs 0, no pulse, period_valid returns only after two further ref edges.
